// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter
//   Eight-requester round-robin arbiter. Produces a registered 3-bit select
//   code (gnt_idx) with a valid qualifier. The arbiter bounds grant length with
//   an optional hold timeout and always inserts at least one idle cycle between
//   grants.
//
// Ports
//   clk           : system clock, all state updates on the rising edge
//   rst           : synchronous, active-high reset
//   req[7:0]      : level-sensitive request lines, bit i = requester i
//   done          : one-cycle release strobe from the current owner
//   gnt_idx[2:0]  : registered index of the granted requester
//   gnt_valid     : registered, high while gnt_idx is an active grant
//   timeout_pulse : registered one-cycle pulse, a grant was ended by timeout
//
// Parameters
//   TIMEOUT       : maximum consecutive grant cycles (0..255), 0 disables

module rr_select_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout_pulse
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic       LP_TO_EN = (TIMEOUT != 0);
  localparam logic [7:0] LP_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic       r_pulse;
  logic       w_pulse_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;

  logic [2:0] w_winner;
  logic       w_found;
  logic       w_done_exit;
  logic       w_req_exit;
  logic       w_to_exit;

  // First set request bit, scanning upward from ptr with wrap 7 -> 0.
  always_comb begin
    logic [2:0] cand;
    w_winner = r_ptr;
    w_found  = 1'b0;
    cand     = r_ptr;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = r_ptr + 3'(k);
      if (!w_found && req[cand]) begin
        w_winner = cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_done_exit = done;
  assign w_req_exit  = !req[r_idx];
  assign w_to_exit   = LP_TO_EN && (r_timer == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_timer_nxt = r_timer;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_timer_nxt = '0;
          w_ptr_nxt   = w_winner + 3'd1;
        end
      end
      ST_GRANT: begin
        if (w_done_exit || w_req_exit || w_to_exit) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
          // Pulse only when the timeout alone ended the grant.
          w_pulse_nxt = w_to_exit && !w_done_exit && !w_req_exit;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_pulse <= w_pulse_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign gnt_idx       = r_idx;
  assign gnt_valid     = r_valid;
  assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_rr_select_arbiter.sv
module tb_rr_select_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b, req_c;
  logic       done_a, done_b, done_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       pul_a, pul_b, pul_c;

  int n_assert = 0;
  int n_fail   = 0;

  rr_select_arbiter #(.TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .done(done_a),
    .gnt_idx(idx_a), .gnt_valid(val_a), .timeout_pulse(pul_a)
  );

  rr_select_arbiter #(.TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .done(done_b),
    .gnt_idx(idx_b), .gnt_valid(val_b), .timeout_pulse(pul_b)
  );

  rr_select_arbiter #(.TIMEOUT(0)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .done(done_c),
    .gnt_idx(idx_c), .gnt_valid(val_c), .timeout_pulse(pul_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] rr_exp [5];
    rr_exp[0] = 3'd2; rr_exp[1] = 3'd5; rr_exp[2] = 3'd7;
    rr_exp[3] = 3'd2; rr_exp[4] = 3'd5;

    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_idx_a", 8'(idx_a), 8'd0);
    check("rst_val_a", 8'(val_a), 8'd0);
    check("rst_pul_a", 8'(pul_a), 8'd0);
    check("rst_val_b", 8'(val_b), 8'd0);
    check("rst_val_c", 8'(val_c), 8'd0);

    // Grant requester 5, then reset in the middle of it.
    req_a = 8'h20;
    tick();
    check("pre_rst_val", 8'(val_a), 8'd1);
    check("pre_rst_idx", 8'(idx_a), 8'd5);
    rst = 1'b1;
    tick();
    check("midrst_idx", 8'(idx_a), 8'd0);
    check("midrst_val", 8'(val_a), 8'd0);
    check("midrst_pul", 8'(pul_a), 8'd0);
    tick();
    rst = 1'b0;
    req_a = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_val", 8'(val_a), 8'd0);
    end

    // Latency: one cycle from request sampled to grant.
    req_a = 8'h08;
    check("lat_before", 8'(val_a), 8'd0);
    tick();
    check("lat_val", 8'(val_a), 8'd1);
    check("lat_idx", 8'(idx_a), 8'd3);
    req_a = '0;
    tick();
    check("lat_release", 8'(val_a), 8'd0);

    // Round-robin with wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 8'b1010_0100;
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        check("rr_val", 8'(val_a), 8'd1);
        check("rr_idx", 8'(idx_a), 8'(rr_exp[g]));
        if (c < 2) tick();
      end
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("rr_gap", 8'(val_a), 8'd0);
      tick();
    end
    req_a = '0;
    tick();
    tick();

    // Timeout with TIMEOUT=4.
    req_b = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_val", 8'(val_b), 8'd1);
      check("to_idx", 8'(idx_b), 8'd3);
      check("to_nopul", 8'(pul_b), 8'd0);
    end
    tick();
    check("to_gap_val", 8'(val_b), 8'd0);
    check("to_gap_pul", 8'(pul_b), 8'd1);
    tick();
    check("to_regrant_val", 8'(val_b), 8'd1);
    check("to_regrant_idx", 8'(idx_b), 8'd3);
    check("to_regrant_pul", 8'(pul_b), 8'd0);
    req_b = '0;
    tick();
    check("to_rel_val", 8'(val_b), 8'd0);
    check("to_rel_pul", 8'(pul_b), 8'd0);
    tick();

    // done coincident with the timeout cycle is a normal release.
    req_b = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("pri_val", 8'(val_b), 8'd1);
    end
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check("pri_done_val", 8'(val_b), 8'd0);
    check("pri_done_pul", 8'(pul_b), 8'd0);
    tick();
    check("pri_g1_val", 8'(val_b), 8'd1);
    tick();
    check("pri_g2_val", 8'(val_b), 8'd1);
    req_b = '0;
    tick();
    check("pri_drop_val", 8'(val_b), 8'd0);
    check("pri_drop_pul", 8'(pul_b), 8'd0);

    // TIMEOUT=0: grant held indefinitely.
    req_c = 8'h08;
    tick();
    for (int c = 0; c < 300; c++) begin
      check("nto_held", {6'd0, val_c, pul_c}, 8'b10);
      tick();
    end
    check("nto_idx", 8'(idx_c), 8'd3);
    req_c = '0;
    tick();
    check("nto_rel", 8'(val_c), 8'd0);

    // Fairness under full contention.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 8'hFF;
    tick();
    for (int g = 0; g < 10; g++) begin
      check("fair_val", 8'(val_a), 8'd1);
      check("fair_idx", 8'(idx_a), 8'(g % 8));
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("fair_gap", 8'(val_a), 8'd0);
      check("fair_pul", 8'(pul_a), 8'd0);
      tick();
    end
    req_a = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Eight-requester round-robin arbiter that produces the 3-bit select code consumed directly by the decoder3to8 stage (gnt_idx drives its s input).
- Converts independent request lines into one registered, glitch-free index with a valid qualifier.
- Bounds how long a grant can be held, and inserts a mandatory idle gap between grants so the downstream one-hot outputs never switch owner back-to-back.

Parameters:
- TIMEOUT, 16, maximum consecutive cycles a grant may be held. Legal range 0..255; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i is requester i, level-sensitive.
- done  input  1  one-cycle release strobe from the current owner; ignored while gnt_valid=0.
- gnt_idx  output  3  registered index of the granted requester (feeds decoder s).
- gnt_valid  output  1  registered; high while gnt_idx is an active grant.
- timeout_pulse  output  1  registered one-cycle pulse; a grant was ended by timeout.

Behaviour:
- Single clock; reset is synchronous and active-high. rst is sampled on the clk rising edge. When sampled high, in the next cycle: state=IDLE, gnt_idx=0, gnt_valid=0, timeout_pulse=0, ptr=0, timer=0. This applies mid-grant; no partial release is reported.
- Internal state:
  - 2-state FSM: IDLE, GRANT.
  - 3-bit priority pointer ptr.
  - 8-bit hold timer.
- IDLE, req==0: remain in IDLE; outputs hold; gnt_idx keeps its last value with gnt_valid=0.
- IDLE, req!=0: the winner is the first set bit searching ptr, ptr+1, ..., wrapping 7->0, back to ptr-1.
  - Next cycle: state=GRANT, gnt_idx=winner, gnt_valid=1, timer=0, ptr=winner+1 mod 8 (7 wraps to 0).
  - Latency from req sampled to gnt_valid high is 1 cycle.
- GRANT: gnt_idx is held constant. Each cycle, the exit conditions are evaluated in this priority order:
  - (1) done=1
  - (2) req[gnt_idx]=0
  - (3) TIMEOUT!=0 and timer==TIMEOUT-1
- On any exit condition: next cycle state=IDLE, gnt_valid=0.
  - timeout_pulse=1 for that one cycle only if (3) is the sole reason. done coincident with timeout counts as a normal release.
- Otherwise in GRANT, timer increments by 1. The timer never wraps, because the exit fires first; it saturates when TIMEOUT=0.
- A grant therefore lasts at most TIMEOUT cycles with gnt_valid=1.
- Mandatory gap: after every exit there is at least one IDLE cycle with gnt_valid=0 before any new grant. Arbitration occurs in that IDLE cycle, so the new grant appears in the following cycle.
- The ptr update is the only source of fairness. A requester that was just served has lowest priority in the next arbitration, so a timed-out requester still asserting req is re-granted only when no other request is pending.
- Changes on non-granted req bits during GRANT are ignored.
- timeout_pulse is 0 in every cycle except the single pulse cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert rst 2 cycles mid-grant (gnt_idx=5, gnt_valid=1) -> next cycle gnt_idx=0, gnt_valid=0, timeout_pulse=0. Hold req=0 for 10 cycles -> gnt_valid stays 0.
- Round-robin with wrap: after reset, hold req=8'b1010_0100 and pulse done 2 cycles after each grant -> grant sequence 2, 5, 7, 2, 5. Each gnt_valid=1 window is 3 cycles, separated by exactly 1 cycle of gnt_valid=0.
- Latency: from idle, req=8'h08 sampled at edge N -> gnt_valid=1, gnt_idx=3 in cycle N+1.
- Timeout: TIMEOUT=4, req=8'h08 held constant, done=0 -> gnt_valid high exactly 4 cycles; then 1 cycle with gnt_valid=0 and timeout_pulse=1; then regrant idx 3. Repeat check with TIMEOUT=0 -> grant held 300 cycles, no pulse.
- Priority of exits: TIMEOUT=4, assert done in the 4th grant cycle -> gnt_valid falls, timeout_pulse stays 0. Separately, drop req[3] in grant cycle 2 -> gnt_valid falls next cycle, no pulse.
- Fairness under contention: req=8'hFF constant, done pulsed each grant's first cycle -> grants 0,1,...,7,0,1 in order; gnt_valid pattern 1,0 repeating.
